spike_vote_classifier: RTL and testbench
========================================

// Module: spike_vote_classifier
// PURPOSE
//  Synthesizable output-layer vote counter for the RANC grid. It replaces the bench-side per-class tally.
//  Sits on packet_out/packet_out_valid of the output core. Each spike is mapped to a class and counted.
//  On frame_done it argmax-scans the counts and presents the winning class through a valid/ready handshake.
//  It also keeps a sticky bitmap of which output axons spiked during the frame.
// PARAMETERS
//  NUM_CLASSES   3    number of classes (>=1)
//  NUM_OUTPUTS   256  output-core neurons; packet address range 0..NUM_OUTPUTS-1
//  ADDR_WIDTH    8    width of spike_addr (>= $clog2(NUM_OUTPUTS))
//  COUNT_WIDTH   16   per-class vote counter width
//  MAP_MODE      0    0: class = addr % NUM_CLASSES; 1: class = addr / (NUM_OUTPUTS/NUM_CLASSES), clamped to NUM_CLASSES-1
// PORTS
//  clk           in   1                 single clock, all logic on posedge
//  rst_n         in   1                 asynchronous, active-low reset
//  spike_valid   in   1                 output-core packet valid
//  spike_addr    in   ADDR_WIDTH        output-core packet (output neuron index)
//  frame_done    in   1                 one-cycle pulse: all ticks of the current image finished
//  result_valid  out  1                 classification available
//  result_ready  in   1                 consumer accepts result
//  result_class  out  $clog2(NUM_CLASSES) (min 1) winning class index
//  result_votes  out  COUNT_WIDTH       vote count of the winning class
//  spiked_vec    out  NUM_OUTPUTS       sticky per-neuron spiked bitmap for the current frame
//  busy          out  1                 high in SCAN or RESULT state
//  overflow      out  1                 sticky: a class counter saturated this frame
//  spike_err     out  1                 sticky: spike dropped (out of range, or arrived outside ACCUM)
// BEHAVIOUR
//  Reset: state=ACCUM; all counters, spiked_vec, result_*, busy, overflow, spike_err = 0. Takes effect immediately, from any state.
//  FSM ACCUM -> SCAN -> RESULT -> ACCUM.
//  ACCUM:
//   - spike_valid with spike_addr < NUM_OUTPUTS: cnt[class] += 1 (saturating at 2^COUNT_WIDTH-1);
//     spiked_vec[spike_addr] <= 1.
//   - If the increment is blocked by saturation, set overflow.
//   - spike_addr >= NUM_OUTPUTS: no count, no bitmap update; set spike_err.
//   - frame_done -> SCAN. A spike in the same cycle as frame_done is counted in this frame.
//  SCAN: one class per cycle, index k = 0..NUM_CLASSES-1.
//   - k=0 loads best=0, max=cnt[0].
//   - k>0 updates best/max only if cnt[k] > max (strict), so ties resolve to the lowest index.
//   - After k=NUM_CLASSES-1 -> RESULT.
//  Latency: frame_done sampled at edge T -> result_valid=1 after edge T+NUM_CLASSES+1.
//  RESULT:
//   - result_valid=1; result_class, result_votes and spiked_vec are held stable while result_ready=0.
//   - On result_valid && result_ready: clear all cnt, spiked_vec, overflow, spike_err; deassert result_valid;
//     -> ACCUM on the next cycle.
//   - A spike in the handshake cycle is dropped.
//  Outside ACCUM:
//   - spike_valid is dropped and sets spike_err (held until the next handshake).
//   - frame_done is ignored.
//  All-zero counts: result_class=0, result_votes=0.
//  busy = (state != ACCUM). Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1 Defaults; spikes 0,3,4,7,8 then frame_done
//    -> counts {2,2,1}; result_class=0 (tie -> lowest), votes=2; spiked_vec bits 0,3,4,7,8 set.
//  2 Latency: frame_done at cycle 100, NUM_CLASSES=3 -> result_valid first high at cycle 104.
//    With result_ready held high, result_valid is low at cycle 105 and the counters read zero.
//  3 COUNT_WIDTH=4; 20 spikes to addr 2
//    -> result_class=2, votes=15, overflow=1. After the handshake, overflow=0.
//  4 Hold result_ready=0 for 10 cycles and inject spike addr 5
//    -> result stable, spiked_vec[5]=0, spike_err=1. The spike is not counted in the next frame.
//  5 spike addr 1 in the same cycle as frame_done -> counted (class 1 votes=1). spike addr 300 -> spike_err=1, no count.
//  6 MAP_MODE=1, NUM_CLASSES=17, NUM_OUTPUTS=255; spikes 15,16,254 -> class1=2 wins, class16=1.
//    Assert rst_n mid-SCAN -> all outputs 0, state ACCUM.

Source files
------------

// File: rtl/spike_vote_classifier.sv
// Output-layer spike vote counter: tallies spikes per class, argmax-scans on frame_done, offers winner via valid/ready.
// Result valid NUM_CLASSES+1 cycles after frame_done; result held while result_ready is low, new spikes dropped meanwhile.
module spike_vote_classifier #(
  parameter int NUM_CLASSES = 3,
  parameter int NUM_OUTPUTS = 256,
  parameter int ADDR_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16,
  parameter int MAP_MODE    = 0,
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spike_valid,
  input  logic [ADDR_WIDTH-1:0]  spike_addr,
  input  logic                   frame_done,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [CLS_W-1:0]       result_class,
  output logic [COUNT_WIDTH-1:0] result_votes,
  output logic [NUM_OUTPUTS-1:0] spiked_vec,
  output logic                   busy,
  output logic                   overflow,
  output logic                   spike_err
);

  localparam int GROUP = (NUM_OUTPUTS / NUM_CLASSES > 0) ? NUM_OUTPUTS / NUM_CLASSES : 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ACCUM, SCAN, RESULT} state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] cnt [NUM_CLASSES];
  logic [CLS_W-1:0]       k;
  logic [CLS_W-1:0]       best;
  logic [COUNT_WIDTH-1:0] max_cnt;
  logic [COUNT_WIDTH-1:0] cnt_k;
  logic [31:0]            addr_ext;
  logic [31:0]            cls_ext;
  logic                   in_range;
  logic                   handshake;

  assign addr_ext  = 32'(spike_addr);
  assign in_range  = addr_ext < 32'(NUM_OUTPUTS);
  assign handshake = (state == RESULT) && result_valid && result_ready;

  always_comb begin
    cls_ext = '0;
    if (MAP_MODE == 0) begin
      cls_ext = addr_ext % 32'(NUM_CLASSES);
    end else begin
      cls_ext = addr_ext / 32'(GROUP);
      if (cls_ext > 32'(NUM_CLASSES - 1)) cls_ext = 32'(NUM_CLASSES - 1);
    end
  end

  always_comb begin
    cnt_k = '0;
    for (int c = 0; c < NUM_CLASSES; c++)
      if (32'(k) == 32'(c)) cnt_k = cnt[c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      for (int c = 0; c < NUM_CLASSES; c++) cnt[c] <= '0;
      spiked_vec   <= '0;
      k            <= '0;
      best         <= '0;
      max_cnt      <= '0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_votes <= '0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      spike_err    <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (spike_valid) begin
            if (in_range) begin
              for (int c = 0; c < NUM_CLASSES; c++) begin
                if (cls_ext == 32'(c)) begin
                  if (cnt[c] == CNT_MAX) overflow <= 1'b1;
                  else                   cnt[c] <= cnt[c] + COUNT_WIDTH'(1);
                end
              end
              for (int i = 0; i < NUM_OUTPUTS; i++)
                if (addr_ext == 32'(i)) spiked_vec[i] <= 1'b1;
            end else begin
              spike_err <= 1'b1;
            end
          end
          if (frame_done) begin
            state <= SCAN;
            busy  <= 1'b1;
            k     <= '0;
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties; k==0 seeds the running max.
          if (k == '0 || cnt_k > max_cnt) begin
            best    <= k;
            max_cnt <= cnt_k;
          end
          if (32'(k) == 32'(NUM_CLASSES - 1)) state <= RESULT;
          else                                k     <= k + CLS_W'(1);
          if (spike_valid) spike_err <= 1'b1;
        end
        RESULT: begin
          if (handshake) begin
            for (int c = 0; c < NUM_CLASSES; c++) cnt[c] <= '0;
            spiked_vec   <= '0;
            overflow     <= 1'b0;
            spike_err    <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= ACCUM;
          end else begin
            if (!result_valid) begin
              result_valid <= 1'b1;
              result_class <= best;
              result_votes <= max_cnt;
            end
            if (spike_valid) spike_err <= 1'b1;
          end
        end
        default: begin
          state <= ACCUM;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_vote_classifier.sv
// Bench for spike_vote_classifier: frame-level reference model checked every cycle, plus directed literal cases.
module tb_spike_vote_classifier;
  localparam int NC = 3;
  localparam int NO = 256;
  localparam int AW = 9;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sv = 1'b0;
  logic [AW-1:0] sa = '0;
  logic fd = 1'b0;
  logic rr = 1'b0;
  logic rv;
  logic [1:0] rc;
  logic [CW-1:0] rvo;
  logic [NO-1:0] svec;
  logic busy, ovf, serr;

  logic rst_n_b = 1'b0;
  logic sv_b = 1'b0;
  logic [7:0] sa_b = '0;
  logic fd_b = 1'b0;
  logic rr_b = 1'b0;
  logic rv_b;
  logic [4:0] rc_b;
  logic [15:0] rvo_b;
  logic [254:0] svec_b;
  logic busy_b, ovf_b, serr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_vote_classifier #(.NUM_CLASSES(NC), .NUM_OUTPUTS(NO), .ADDR_WIDTH(AW),
                          .COUNT_WIDTH(CW), .MAP_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .spike_valid(sv), .spike_addr(sa), .frame_done(fd),
    .result_valid(rv), .result_ready(rr), .result_class(rc), .result_votes(rvo),
    .spiked_vec(svec), .busy(busy), .overflow(ovf), .spike_err(serr));

  spike_vote_classifier #(.NUM_CLASSES(17), .NUM_OUTPUTS(255), .ADDR_WIDTH(8),
                          .COUNT_WIDTH(16), .MAP_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .spike_valid(sv_b), .spike_addr(sa_b), .frame_done(fd_b),
    .result_valid(rv_b), .result_ready(rr_b), .result_class(rc_b), .result_votes(rvo_b),
    .spiked_vec(svec_b), .busy(busy_b), .overflow(ovf_b), .spike_err(serr_b));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frame-level tallies, winner computed at frame end, result due NC+1 edges later.
  int m_cnt [NC];
  logic [NO-1:0] m_vec = '0;
  bit m_ovf = 0, m_err = 0, m_busy = 0, m_valid = 0;
  int m_cls = 0, m_votes = 0, ecount = 0, m_due = 0;

  task automatic model_clear();
    for (int c = 0; c < NC; c++) m_cnt[c] = 0;
    m_vec = '0;
    m_ovf = 0;
    m_err = 0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
        m_busy = 0;
        m_valid = 0;
      end else begin
        int a;
        a = int'(sa);
        ecount++;
        if (!m_busy) begin
          if (sv) begin
            if (a < NO) begin
              if (m_cnt[a % NC] == (1 << CW) - 1) m_ovf = 1;
              else m_cnt[a % NC]++;
              m_vec[a] = 1'b1;
            end else begin
              m_err = 1;
            end
          end
          if (fd) begin
            m_busy = 1;
            m_due = ecount + NC + 1;
            m_cls = 0;
            m_votes = m_cnt[0];
            for (int c = 1; c < NC; c++)
              if (m_cnt[c] > m_votes) begin
                m_cls = c;
                m_votes = m_cnt[c];
              end
          end
        end else if (m_valid && rr) begin
          model_clear();
          m_valid = 0;
          m_busy = 0;
        end else begin
          if (sv) m_err = 1;
          if (ecount == m_due) m_valid = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("result_valid", 256'(rv), 256'(m_valid));
    chk("busy", 256'(busy), 256'(m_busy));
    chk("overflow", 256'(ovf), 256'(m_ovf));
    chk("spike_err", 256'(serr), 256'(m_err));
    chk("spiked_vec", 256'(svec), 256'(m_vec));
    if (m_valid) begin
      chk("result_class", 256'(rc), 256'(m_cls));
      chk("result_votes", 256'(rvo), 256'(m_votes));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spike(input int a);
    sv = 1'b1;
    sa = AW'(a);
    tick();
    sv = 1'b0;
  endtask

  task automatic frame();
    fd = 1'b1;
    tick();
    fd = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!rv && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rv) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: result_valid still 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic accept();
    rr = 1'b1;
    tick();
    rr = 1'b0;
  endtask

  task automatic wait_valid_b();
    int n = 0;
    while (!rv_b && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rv_b) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_b: result_valid still 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic spike_b(input int a);
    sv_b = 1'b1;
    sa_b = 8'(a);
    tick();
    sv_b = 1'b0;
  endtask

  task automatic frame_b();
    fd_b = 1'b1;
    tick();
    fd_b = 1'b0;
  endtask

  task automatic rand_spike();
    sv = 1'($urandom % 2);
    if ($urandom % 10 == 0) sa = AW'($urandom_range(256, 511));
    else if ($urandom % 2 == 0) sa = AW'(3 * $urandom_range(0, 84));
    else sa = AW'($urandom_range(0, 255));
  endtask

  initial begin
    logic [255:0] ev;
    repeat (3) @(negedge clk);
    chk("reset_class", 256'(rc), 256'(0));
    chk("reset_votes", 256'(rvo), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rst_n_b = 1'b1;

    // Case 1: tie between classes 0 and 1 resolves to 0
    spike(0); spike(3); spike(4); spike(7); spike(8);
    frame();
    wait_valid();
    chk("t1_class", 256'(rc), 256'(0));
    chk("t1_votes", 256'(rvo), 256'(2));
    ev = '0;
    ev[0] = 1'b1; ev[3] = 1'b1; ev[4] = 1'b1; ev[7] = 1'b1; ev[8] = 1'b1;
    chk("t1_vec", 256'(svec), ev);
    accept();

    // Case 2: latency with result_ready held high, then an empty frame
    tick(); tick();
    rr = 1'b1;
    frame();
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t2_latency", 256'(rv), 256'(i == 4));
    end
    rr = 1'b0;
    frame();
    wait_valid();
    chk("t2_zero_class", 256'(rc), 256'(0));
    chk("t2_zero_votes", 256'(rvo), 256'(0));
    accept();

    // Case 3: saturation at 2^CW-1
    repeat (20) spike(2);
    frame();
    wait_valid();
    chk("t3_class", 256'(rc), 256'(2));
    chk("t3_votes", 256'(rvo), 256'(15));
    chk("t3_ovf", 256'(ovf), 256'(1));
    accept();
    @(negedge clk);
    chk("t3_ovf_clear", 256'(ovf), 256'(0));

    // Case 4: result held under backpressure, late spike dropped
    spike(0);
    frame();
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin sv = 1'b1; sa = AW'(5); end
      tick();
      sv = 1'b0;
      @(negedge clk);
      chk("t4_hold_valid", 256'(rv), 256'(1));
      chk("t4_hold_class", 256'(rc), 256'(0));
      chk("t4_hold_votes", 256'(rvo), 256'(1));
    end
    chk("t4_vec5", 256'(svec[5]), 256'(0));
    chk("t4_err", 256'(serr), 256'(1));
    accept();
    @(negedge clk);
    chk("t4_err_clear", 256'(serr), 256'(0));
    frame();
    wait_valid();
    chk("t4_next_votes", 256'(rvo), 256'(0));
    accept();

    // Case 5: out-of-range address, spike coincident with frame_done
    spike(300);
    @(negedge clk);
    chk("t5_err", 256'(serr), 256'(1));
    sv = 1'b1; sa = AW'(1); fd = 1'b1;
    tick();
    sv = 1'b0; fd = 1'b0;
    wait_valid();
    chk("t5_class", 256'(rc), 256'(1));
    chk("t5_votes", 256'(rvo), 256'(1));
    ev = '0;
    ev[1] = 1'b1;
    chk("t5_vec", 256'(svec), ev);
    accept();

    // Random frames with random backpressure and stray spikes/frame_done while busy
    repeat (40) begin
      int len, n;
      len = $urandom_range(5, 60);
      for (int j = 0; j < len; j++) begin
        rand_spike();
        rr = 1'($urandom % 2);
        tick();
      end
      rand_spike();
      fd = 1'b1;
      tick();
      n = 0;
      while (m_busy && n < 200) begin
        rand_spike();
        fd = 1'($urandom % 4 == 0);
        rr = 1'($urandom % 3 == 0);
        tick();
        n++;
      end
      sv = 1'b0; fd = 1'b0; rr = 1'b0;
      if (m_busy) begin
        checks++;
        errors++;
        $display("FAIL rand_drain: busy still 1 after %0d cycles, expected 0", n);
      end
    end

    // Case 6: range mapping, 17 classes over 255 outputs, reset mid-scan
    spike_b(15); spike_b(16); spike_b(254);
    frame_b();
    wait_valid_b();
    chk("t6_class", 256'(rc_b), 256'(1));
    chk("t6_votes", 256'(rvo_b), 256'(2));
    chk("t6_busy", 256'(busy_b), 256'(1));
    rr_b = 1'b1;
    tick();
    rr_b = 1'b0;
    spike_b(3);
    frame_b();
    tick(); tick(); tick();
    rst_n_b = 1'b0;
    #1;
    chk("t6_rst_valid", 256'(rv_b), 256'(0));
    chk("t6_rst_busy", 256'(busy_b), 256'(0));
    chk("t6_rst_class", 256'(rc_b), 256'(0));
    chk("t6_rst_votes", 256'(rvo_b), 256'(0));
    chk("t6_rst_vec", 256'(svec_b), 256'(0));
    chk("t6_rst_flags", 256'({ovf_b, serr_b}), 256'(0));
    tick();
    rst_n_b = 1'b1;
    spike_b(254);
    frame_b();
    wait_valid_b();
    chk("t6_c16_class", 256'(rc_b), 256'(16));
    chk("t6_c16_votes", 256'(rvo_b), 256'(1));
    rr_b = 1'b1;
    tick();
    rr_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
